mu0_control_fsm: RTL and testbench

MU0_CONTROL_FSM -- requirements
Module: mu0_control_fsm

---
 rtl/mu0_pkg.sv | 57 +++++
 rtl/mu0_opdecode.sv | 22 ++
 rtl/mu0_control_fsm.sv | 133 +++++++++++++
 tb/tb_mu0_control_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared types for the MU0 controller: opcodes, FSM states, ALU operations
// and the one-hot instruction class produced by the opcode decoder.
package mu0_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'd0,
    OP_STA = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_JMP = 4'd4,
    OP_JMI = 4'd5,
    OP_JEQ = 4'd6,
    OP_STP = 4'd7,
    OP_LDI = 4'd8,
    OP_LSL = 4'd9,
    OP_LSR = 4'd10
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_PASS = 3'd2,
    ALU_SHL  = 3'd3,
    ALU_SHR  = 3'd4
  } alu_op_t;

  // Exactly one bit set for any 4-bit opcode; codes 11-15 land in illegal.
  typedef struct packed {
    logic ld_alu;
    logic store;
    logic jump;
    logic ldi;
    logic shift;
    logic stop;
    logic illegal;
  } iclass_t;

  localparam int OPCODE_W = 4;

  function automatic alu_op_t alu_for_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_LSL:  return ALU_SHL;
      OP_LSR:  return ALU_SHR;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mu0_opdecode.sv
// Combinational opcode-to-instruction-class decoder for the MU0 controller.
module mu0_opdecode
  import mu0_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             iclass
);

  always_comb begin
    iclass = '0;
    case (opcode)
      OP_LDA, OP_ADD, OP_SUB: iclass.ld_alu  = 1'b1;
      OP_STA:                 iclass.store   = 1'b1;
      OP_JMP, OP_JMI, OP_JEQ: iclass.jump    = 1'b1;
      OP_STP:                 iclass.stop    = 1'b1;
      OP_LDI:                 iclass.ldi     = 1'b1;
      OP_LSL, OP_LSR:         iclass.shift   = 1'b1;
      default:                iclass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_control_fsm.sv
// MU0 control sequencer: holds the instruction register and drives datapath strobes.
//   state | meaning
//   FETCH | read mem[PC] into IR, PC+1
//   EXEC1 | decode IR; single-cycle ops complete here
//   EXEC2 | second cycle of LDA/ADD/SUB: accumulator write
//   HALT  | stopped after STP; start resumes at FETCH
module mu0_control_fsm
  import mu0_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int ADDR_W = DATA_W - 4,
  localparam int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              eq,
  input  logic              mi,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              addr_sel,
  output logic              ram_wr_en,
  output logic              acc_en,
  output logic              acc_src,
  output alu_op_t           alu_op,
  output logic [SH_W-1:0]   shamt,
  output logic              shift_in,
  output logic [ADDR_W-1:0] operand,
  output state_t            state,
  output logic              halted,
  output logic              illegal
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [OPCODE_W-1:0] opcode;
  iclass_t             iclass;
  logic                jump_taken;

  assign opcode  = ir_q[DATA_W-1 -: OPCODE_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign state   = state_q;
  assign halted  = (state_q == ST_HALT);

  mu0_opdecode u_opdecode (
    .opcode (opcode),
    .iclass (iclass)
  );

  // Flags only matter in EXEC1; elsewhere jump_taken is ignored.
  assign jump_taken = (opcode == OP_JMP)
                   || ((opcode == OP_JMI) && mi)
                   || ((opcode == OP_JEQ) && eq);

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    addr_sel  = 1'b0;
    ram_wr_en = 1'b0;
    acc_en    = 1'b0;
    acc_src   = 1'b0;
    alu_op    = ALU_PASS;
    shamt     = '0;
    shift_in  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = ST_EXEC1;
      end
      ST_EXEC1: begin
        state_d = ST_FETCH;
        if (iclass.ld_alu) begin
          addr_sel = 1'b1;
          state_d  = ST_EXEC2;
        end
        if (iclass.store) begin
          addr_sel  = 1'b1;
          ram_wr_en = 1'b1;
        end
        if (iclass.jump) pc_load = jump_taken;
        if (iclass.ldi) begin
          acc_en  = 1'b1;
          acc_src = 1'b1;
        end
        // A zero shift still writes back so the accumulator flags refresh.
        if (iclass.shift) begin
          acc_en   = 1'b1;
          alu_op   = alu_for_op(opcode);
          shamt    = operand[SH_W-1:0];
          shift_in = (opcode == OP_LSR) && mi;
        end
        if (iclass.stop) state_d = ST_HALT;
        if (iclass.illegal) illegal = 1'b1;
      end
      ST_EXEC2: begin
        acc_en   = 1'b1;
        addr_sel = 1'b1;
        alu_op   = alu_for_op(opcode);
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (reset) begin
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      ram_wr_en = 1'b0;
      acc_en    = 1'b0;
      illegal   = 1'b0;
    end
    ir_d = ir_load ? mem_rdata : ir_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_mu0_control_fsm.sv
// Self-checking bench for mu0_control_fsm (DATA_W=16): instruction table plus reset/halt sequences.
module tb_mu0_control_fsm;
  import mu0_pkg::*;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] mem_rdata;
  logic        eq;
  logic        mi;
  logic        ir_load, pc_inc, pc_load, addr_sel, ram_wr_en, acc_en, acc_src;
  alu_op_t     alu_op;
  logic [3:0]  shamt;
  logic        shift_in;
  logic [11:0] operand;
  state_t      state;
  logic        halted;
  logic        illegal;

  mu0_control_fsm #(.DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_rdata (mem_rdata),
    .eq        (eq),
    .mi        (mi),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .addr_sel  (addr_sel),
    .ram_wr_en (ram_wr_en),
    .acc_en    (acc_en),
    .acc_src   (acc_src),
    .alu_op    (alu_op),
    .shamt     (shamt),
    .shift_in  (shift_in),
    .operand   (operand),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  state;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic        addr_sel;
    logic        ram_wr_en;
    logic        acc_en;
    logic        acc_src;
    logic [2:0]  alu_op;
    logic [3:0]  shamt;
    logic        shift_in;
    logic [11:0] operand;
    logic        halted;
    logic        illegal;
  } outs_t;

  typedef struct packed {
    logic [15:0] instr;
    logic        eq;
    logic        mi;
    logic        start;
    logic        addr_sel;
    logic        pc_load;
    logic        ram_wr;
    logic        acc_en;
    logic        acc_src;
    logic [2:0]  alu;
    logic [3:0]  shamt;
    logic        shift_in;
    logic        illegal;
    logic [1:0]  nxt;
    logic [2:0]  e2alu;
  } vec_t;

  outs_t act;
  assign act = {state, ir_load, pc_inc, pc_load, addr_sel, ram_wr_en, acc_en, acc_src,
                alu_op, shamt, shift_in, operand, halted, illegal};

  outs_t sb_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic outs_t base(input logic [1:0] st, input logic [11:0] op);
    outs_t e;
    e         = '0;
    e.state   = st;
    e.alu_op  = ALU_PASS;
    e.operand = op;
    e.halted  = (st == ST_HALT);
    return e;
  endfunction

  function automatic outs_t fetch_exp(input logic [11:0] op);
    outs_t e;
    e         = base(ST_FETCH, op);
    e.ir_load = 1'b1;
    e.pc_inc  = 1'b1;
    return e;
  endfunction

  task automatic cyc(input logic [15:0] rd, input logic e_in, input logic m_in,
                     input logic r_in, input logic s_in, input outs_t exp, input string nm);
    @(negedge clk);
    mem_rdata = rd;
    eq        = e_in;
    mi        = m_in;
    reset     = r_in;
    start     = s_in;
    sb_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  task automatic check_now(input logic [31:0] got, input logic [31:0] exp, input string nm);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  initial begin
    outs_t exp;
    string nm;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        nm  = nm_q.pop_front();
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", nm, act, exp);
        end
      end
    end
  end

  vec_t tbl[15];

  initial begin
    outs_t       e;
    logic [11:0] prev_op;
    reset     = 1'b1;
    start     = 1'b0;
    mem_rdata = '0;
    eq        = 1'b0;
    mi        = 1'b0;

    //           instr     eq mi st asel pcl wr acc src alu       sh    sin ill nxt       e2alu
    tbl[0]  = '{16'h0123, O, O, O, I,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_EXEC2, ALU_PASS};
    tbl[1]  = '{16'h2010, O, O, I, I,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_EXEC2, ALU_ADD};
    tbl[2]  = '{16'h3011, I, I, O, I,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_EXEC2, ALU_SUB};
    tbl[3]  = '{16'h6040, I, O, O, O,   I,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[4]  = '{16'h6040, O, I, I, O,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[5]  = '{16'h5041, O, I, O, O,   I,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[6]  = '{16'h5041, I, O, O, O,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[7]  = '{16'h4042, O, O, I, O,   I,  O, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[8]  = '{16'h1005, O, O, O, I,   O,  I, O,  O,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[9]  = '{16'h8ABC, I, I, O, O,   O,  O, I,  I,  ALU_PASS, 4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[10] = '{16'hA003, O, I, O, O,   O,  O, I,  O,  ALU_SHR,  4'd3, I,  O,  ST_FETCH, ALU_PASS};
    tbl[11] = '{16'h9000, O, O, O, O,   O,  O, I,  O,  ALU_SHL,  4'd0, O,  O,  ST_FETCH, ALU_PASS};
    tbl[12] = '{16'h9FF7, O, I, O, O,   O,  O, I,  O,  ALU_SHL,  4'd7, O,  O,  ST_FETCH, ALU_PASS};
    tbl[13] = '{16'hC000, I, I, I, O,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  I,  ST_FETCH, ALU_PASS};
    tbl[14] = '{16'hF123, O, O, O, O,   O,  O, O,  O,  ALU_PASS, 4'd0, O,  I,  ST_FETCH, ALU_PASS};

    cyc(16'h0000, O, O, I, O, base(ST_FETCH, 12'h000), "reset_idle");
    #2;
    check_now(32'(state),   32'(ST_FETCH), "reset_state");
    check_now(32'(halted),  32'd0,         "reset_halted");
    check_now(32'(operand), 32'd0,         "reset_operand");
    check_now(32'(acc_src), 32'd0,         "reset_acc_src");
    check_now(32'(alu_op),  32'(ALU_PASS), "reset_alu_op");
    check_now(32'(shamt),   32'd0,         "reset_shamt");

    prev_op = 12'h000;
    foreach (tbl[i]) begin
      cyc(tbl[i].instr, tbl[i].eq, tbl[i].mi, O, O, fetch_exp(prev_op), $sformatf("v%0d_fetch", i));
      e           = base(ST_EXEC1, tbl[i].instr[11:0]);
      e.addr_sel  = tbl[i].addr_sel;
      e.pc_load   = tbl[i].pc_load;
      e.ram_wr_en = tbl[i].ram_wr;
      e.acc_en    = tbl[i].acc_en;
      e.acc_src   = tbl[i].acc_src;
      e.alu_op    = tbl[i].alu;
      e.shamt     = tbl[i].shamt;
      e.shift_in  = tbl[i].shift_in;
      e.illegal   = tbl[i].illegal;
      cyc(~tbl[i].instr, tbl[i].eq, tbl[i].mi, O, tbl[i].start, e, $sformatf("v%0d_exec1", i));
      if (tbl[i].nxt == ST_EXEC2) begin
        e          = base(ST_EXEC2, tbl[i].instr[11:0]);
        e.acc_en   = 1'b1;
        e.addr_sel = 1'b1;
        e.alu_op   = tbl[i].e2alu;
        cyc(~tbl[i].instr, O, O, O, O, e, $sformatf("v%0d_exec2", i));
      end
      prev_op = tbl[i].instr[11:0];
    end

    cyc(16'h7000, O, O, O, O, fetch_exp(prev_op), "stp_fetch");
    cyc(16'h1234, I, I, O, O, base(ST_EXEC1, 12'h000), "stp_exec1");
    for (int k = 0; k < 10; k++)
      cyc(16'h0FFF, I, I, O, O, base(ST_HALT, 12'h000), $sformatf("halt_%0d", k));
    #2;
    check_now(32'(halted), 32'd1,         "halt_wait_expired_halted");
    check_now(32'(state),  32'(ST_HALT),  "halt_wait_expired_state");
    cyc(16'h0FFF, O, O, O, I, base(ST_HALT, 12'h000), "halt_start");
    cyc(16'h0777, O, O, O, O, fetch_exp(12'h000), "resume_fetch");

    cyc(16'h0000, O, O, O, O, base(ST_EXEC1, 12'h777), "rst2_exec1");
    e = base(ST_EXEC1, 12'h777);
    e.addr_sel = 1'b1;
    sb_q[sb_q.size()-1] = e;
    e          = base(ST_EXEC2, 12'h777);
    e.addr_sel = 1'b1;
    cyc(16'h0000, O, O, I, O, e, "rst_in_exec2");
    cyc(16'h1005, O, O, O, O, fetch_exp(12'h000), "rst2_fetch");

    e          = base(ST_EXEC1, 12'h005);
    e.addr_sel = 1'b1;
    cyc(16'h0000, O, O, I, O, e, "rst_in_sta");
    cyc(16'h7000, O, O, O, O, fetch_exp(12'h000), "rst3_fetch");

    cyc(16'h0000, O, O, O, O, base(ST_EXEC1, 12'h000), "stp2_exec1");
    cyc(16'h0000, O, O, I, O, base(ST_HALT, 12'h000), "rst_in_halt");
    cyc(16'h0000, O, O, O, O, fetch_exp(12'h000), "rst4_fetch");

    @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
